// File: rtl/pulse_bank.sv
// pulse_bank: a bank of NES-style rectangle channels sharing one register-write
// port. Each channel owns its register file, period timer, duty sequencer,
// envelope, sweep and length counter. Per-channel volumes are registered and
// their sum is registered once more for the DAC path.
module pulse_bank #(
  parameter int NUM_CH  = 2,
  parameter int TIMER_W = 11,
  parameter int VOL_W   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable_240hz,
  input  logic                      enable_120hz,
  input  logic                      reg_wr,
  input  logic [2:0]                reg_ch,
  input  logic [1:0]                reg_addr,
  input  logic [7:0]                reg_data,
  output logic [NUM_CH*VOL_W-1:0]   pulse_out,
  output logic [VOL_W+2:0]          mix_out,
  output logic [NUM_CH-1:0]         active
);

  // Length-counter load values indexed by the 5-bit field of reg 3.
  function automatic logic [7:0] len_lut(input logic [4:0] idx);
    logic [7:0] v;
    case (idx)
      5'd0:  v = 8'd10;  5'd1:  v = 8'd254; 5'd2:  v = 8'd20;  5'd3:  v = 8'd2;
      5'd4:  v = 8'd40;  5'd5:  v = 8'd4;   5'd6:  v = 8'd80;  5'd7:  v = 8'd6;
      5'd8:  v = 8'd160; 5'd9:  v = 8'd8;   5'd10: v = 8'd60;  5'd11: v = 8'd10;
      5'd12: v = 8'd14;  5'd13: v = 8'd12;  5'd14: v = 8'd26;  5'd15: v = 8'd14;
      5'd16: v = 8'd12;  5'd17: v = 8'd16;  5'd18: v = 8'd24;  5'd19: v = 8'd18;
      5'd20: v = 8'd48;  5'd21: v = 8'd20;  5'd22: v = 8'd96;  5'd23: v = 8'd22;
      5'd24: v = 8'd192; 5'd25: v = 8'd24;  5'd26: v = 8'd72;  5'd27: v = 8'd26;
      5'd28: v = 8'd16;  5'd29: v = 8'd28;  5'd30: v = 8'd32;  default: v = 8'd30;
    endcase
    return v;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      // Channel 0 negates with ones' complement (one extra subtracted).
      localparam bit ONES_NEG = (gi == 0);

      logic [1:0]         duty_q, duty_d;
      logic               halt_q, halt_d, const_q, const_d;
      logic [3:0]         vol_q, vol_d;
      logic               sw_en_q, sw_en_d, neg_q, neg_d, sw_reload_q, sw_reload_d;
      logic [2:0]         sw_p_q, sw_p_d, shift_q, shift_d, sw_div_q, sw_div_d;
      logic [TIMER_W-1:0] period_q, period_d, timer_q, timer_d;
      logic [2:0]         step_q, step_d;
      logic [7:0]         len_q, len_d;
      logic               env_start_q, env_start_d;
      logic [3:0]         decay_q, decay_d, env_div_q, env_div_d;
      logic [VOL_W-1:0]   pulse_q, pulse_d;
      logic [TIMER_W:0]   delta, target;
      logic               mute, wr_sel;
      logic [3:0]         volume;
      logic [7:0]         pattern;

      assign wr_sel = reg_wr && (reg_ch == 3'(gi));

      // Sweep target in one extra bit so an add overflow is visible as a mute.
      always_comb begin
        delta = {1'b0, period_q} >> shift_q;
        if (!neg_q)        target = {1'b0, period_q} + delta;
        else if (ONES_NEG) target = {1'b0, period_q} - delta - (TIMER_W+1)'(1);
        else               target = {1'b0, period_q} - delta;
        mute = (len_q == '0) || (period_q < TIMER_W'(8)) || (!neg_q && target[TIMER_W]);
      end

      // Next-state for timer, envelope, sweep, length; register writes win last.
      always_comb begin
        duty_d = duty_q; halt_d = halt_q; const_d = const_q; vol_d = vol_q;
        sw_en_d = sw_en_q; sw_p_d = sw_p_q; neg_d = neg_q; shift_d = shift_q;
        sw_reload_d = sw_reload_q; sw_div_d = sw_div_q;
        period_d = period_q; timer_d = timer_q; step_d = step_q; len_d = len_q;
        env_start_d = env_start_q; decay_d = decay_q; env_div_d = env_div_q;

        if (timer_q == '0) begin
          timer_d = period_q;
          step_d  = step_q + 3'd1;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end

        if (enable_240hz) begin
          if (env_start_q) begin
            env_start_d = 1'b0;
            decay_d     = 4'd15;
            env_div_d   = vol_q;
          end else if (env_div_q == 4'd0) begin
            env_div_d = vol_q;
            if (decay_q != 4'd0) decay_d = decay_q - 4'd1;
            else if (halt_q)     decay_d = 4'd15;
          end else begin
            env_div_d = env_div_q - 4'd1;
          end
        end

        if (enable_120hz) begin
          if (sw_div_q == 3'd0 && sw_en_q && shift_q != 3'd0 && !mute)
            period_d = target[TIMER_W-1:0];
          if (sw_div_q == 3'd0 || sw_reload_q) begin
            sw_div_d    = sw_p_q;
            sw_reload_d = 1'b0;
          end else begin
            sw_div_d = sw_div_q - 3'd1;
          end
          if (!halt_q && len_q != 8'd0) len_d = len_q - 8'd1;
        end

        if (wr_sel) begin
          case (reg_addr)
            2'd0: {duty_d, halt_d, const_d, vol_d} = reg_data;
            2'd1: begin
              {sw_en_d, sw_p_d, neg_d, shift_d} = reg_data;
              sw_reload_d = 1'b1;
            end
            2'd2: period_d = {period_q[TIMER_W-1:8], reg_data};
            default: begin
              period_d    = {reg_data[2:0], period_q[7:0]};
              len_d       = len_lut(reg_data[7:3]);
              env_start_d = 1'b1;
              step_d      = 3'd0;
            end
          endcase
        end
      end

      // Output volume from the current duty step; bit s of pattern is step s.
      always_comb begin
        case (duty_q)
          2'd0:    pattern = 8'b0000_0010;
          2'd1:    pattern = 8'b0000_0110;
          2'd2:    pattern = 8'b0001_1110;
          default: pattern = 8'b1111_1001;
        endcase
        volume  = const_q ? vol_q : decay_q;
        pulse_d = (pattern[step_q] && !mute) ? VOL_W'(volume) : '0;
      end

      // Channel state registers.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          duty_q <= '0; halt_q <= 1'b0; const_q <= 1'b0; vol_q <= '0;
          sw_en_q <= 1'b0; sw_p_q <= '0; neg_q <= 1'b0; shift_q <= '0;
          sw_reload_q <= 1'b0; sw_div_q <= '0;
          period_q <= '0; timer_q <= '0; step_q <= '0; len_q <= '0;
          env_start_q <= 1'b0; decay_q <= '0; env_div_q <= '0; pulse_q <= '0;
        end else begin
          duty_q <= duty_d; halt_q <= halt_d; const_q <= const_d; vol_q <= vol_d;
          sw_en_q <= sw_en_d; sw_p_q <= sw_p_d; neg_q <= neg_d; shift_q <= shift_d;
          sw_reload_q <= sw_reload_d; sw_div_q <= sw_div_d;
          period_q <= period_d; timer_q <= timer_d; step_q <= step_d; len_q <= len_d;
          env_start_q <= env_start_d; decay_q <= decay_d; env_div_q <= env_div_d;
          pulse_q <= pulse_d;
        end
      end

      assign pulse_out[gi*VOL_W +: VOL_W] = pulse_q;
      assign active[gi] = (len_q != 8'd0);
    end
  endgenerate

  logic [VOL_W+2:0] mix_d, mix_q;

  // Sum of the registered channel volumes.
  always_comb begin
    mix_d = '0;
    for (int k = 0; k < NUM_CH; k++)
      mix_d = mix_d + (VOL_W+3)'(pulse_out[k*VOL_W +: VOL_W]);
  end

  // Mix register feeding the DAC path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mix_q <= '0;
    else        mix_q <= mix_d;
  end

  assign mix_out = mix_q;

endmodule

// File: tb/tb_pulse_bank.sv
// tb_pulse_bank: directed and randomized stimulus for a 4-channel pulse_bank.
// A reference model steps once per clock and pushes the expected outputs into
// a scoreboard queue; a monitor pops one entry per cycle and compares.
module tb_pulse_bank;
  localparam int NCH = 4;
  localparam int VOL = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic enable_240hz, enable_120hz;
  logic reg_wr;
  logic [2:0] reg_ch;
  logic [1:0] reg_addr;
  logic [7:0] reg_data;
  logic [NCH*VOL-1:0] pulse_out;
  logic [VOL+2:0] mix_out;
  logic [NCH-1:0] active;

  pulse_bank #(.NUM_CH(NCH), .TIMER_W(11), .VOL_W(VOL)) dut (
    .clk(clk), .rst_n(rst_n), .enable_240hz(enable_240hz), .enable_120hz(enable_120hz),
    .reg_wr(reg_wr), .reg_ch(reg_ch), .reg_addr(reg_addr), .reg_data(reg_data),
    .pulse_out(pulse_out), .mix_out(mix_out), .active(active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NCH*VOL-1:0] pulse;
    logic [VOL+2:0]     mix;
    logic [NCH-1:0]     act;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;
  int rate240 = 0;
  int rate120 = 0;

  // ---------------- reference model ----------------
  int len_tab[32] = '{10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,
                      12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30};
  int duty_tab[4][8] = '{'{0,1,0,0,0,0,0,0}, '{0,1,1,0,0,0,0,0},
                         '{0,1,1,1,1,0,0,0}, '{1,0,0,1,1,1,1,1}};
  int m_duty[NCH], m_halt[NCH], m_cvol[NCH], m_volp[NCH];
  int m_sen[NCH], m_sp[NCH], m_neg[NCH], m_shift[NCH], m_sreload[NCH], m_sdiv[NCH];
  int m_period[NCH], m_timer[NCH], m_step[NCH], m_len[NCH];
  int m_estart[NCH], m_decay[NCH], m_ediv[NCH], m_pulse[NCH];

  function automatic int sweep_target(int ch);
    int d = m_period[ch] >> m_shift[ch];
    if (m_neg[ch] == 0) return m_period[ch] + d;
    return m_period[ch] - d - ((ch == 0) ? 1 : 0);
  endfunction

  function automatic bit muted(int ch);
    return (m_len[ch] == 0) || (m_period[ch] < 8) ||
           (m_neg[ch] == 0 && sweep_target(ch) > 'h7FF);
  endfunction

  task automatic model_tick();
    exp_t e;
    int sum, vol, tgt, oldp;
    bit mt;
    e.pulse = '0; e.mix = '0; e.act = '0;
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        m_duty[c] = 0; m_halt[c] = 0; m_cvol[c] = 0; m_volp[c] = 0;
        m_sen[c] = 0; m_sp[c] = 0; m_neg[c] = 0; m_shift[c] = 0; m_sreload[c] = 0; m_sdiv[c] = 0;
        m_period[c] = 0; m_timer[c] = 0; m_step[c] = 0; m_len[c] = 0;
        m_estart[c] = 0; m_decay[c] = 0; m_ediv[c] = 0; m_pulse[c] = 0;
      end
      sb.push_back(e);
      return;
    end
    sum = 0;
    for (int c = 0; c < NCH; c++) sum += m_pulse[c];
    for (int c = 0; c < NCH; c++) begin
      vol = (m_cvol[c] != 0) ? m_volp[c] : m_decay[c];
      m_pulse[c] = (duty_tab[m_duty[c]][m_step[c]] == 1 && !muted(c)) ? vol : 0;
    end
    for (int c = 0; c < NCH; c++) begin
      mt = muted(c);
      tgt = sweep_target(c);
      oldp = m_period[c];
      if (m_timer[c] == 0) begin m_timer[c] = m_period[c]; m_step[c] = (m_step[c] + 1) % 8; end
      else m_timer[c]--;
      if (enable_240hz) begin
        if (m_estart[c] != 0) begin m_estart[c] = 0; m_decay[c] = 15; m_ediv[c] = m_volp[c]; end
        else if (m_ediv[c] == 0) begin
          m_ediv[c] = m_volp[c];
          if (m_decay[c] > 0) m_decay[c]--;
          else if (m_halt[c] != 0) m_decay[c] = 15;
        end else m_ediv[c]--;
      end
      if (enable_120hz) begin
        if (m_sdiv[c] == 0 && m_sen[c] != 0 && m_shift[c] != 0 && !mt) m_period[c] = tgt;
        if (m_sdiv[c] == 0 || m_sreload[c] != 0) begin m_sdiv[c] = m_sp[c]; m_sreload[c] = 0; end
        else m_sdiv[c]--;
        if (m_halt[c] == 0 && m_len[c] > 0) m_len[c]--;
      end
      if (reg_wr && int'(reg_ch) == c) begin
        case (reg_addr)
          2'd0: begin
            m_duty[c] = reg_data / 64; m_halt[c] = (reg_data / 32) % 2;
            m_cvol[c] = (reg_data / 16) % 2; m_volp[c] = reg_data % 16;
          end
          2'd1: begin
            m_sen[c] = reg_data / 128; m_sp[c] = (reg_data / 16) % 8;
            m_neg[c] = (reg_data / 8) % 2; m_shift[c] = reg_data % 8; m_sreload[c] = 1;
          end
          2'd2: m_period[c] = (oldp / 256) * 256 + int'(reg_data);
          default: begin
            m_period[c] = (reg_data % 8) * 256 + oldp % 256;
            m_len[c] = len_tab[reg_data / 8]; m_estart[c] = 1; m_step[c] = 0;
          end
        endcase
      end
    end
    for (int c = 0; c < NCH; c++) begin
      e.pulse[c*VOL +: VOL] = 4'(m_pulse[c]);
      e.act[c] = (m_len[c] != 0);
    end
    e.mix = 7'(sum);
    sb.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    model_tick();
  end

  // ---------------- monitor ----------------
  initial forever begin
    exp_t e;
    @(negedge clk);
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty at %0t: no expected entry (have 0, need 1)", $time);
    end else begin
      e = sb.pop_front();
      if (pulse_out !== e.pulse || mix_out !== e.mix || active !== e.act) begin
        n_bad++;
        if (n_bad <= 20)
          $display("FAIL outputs at %0t: pulse_out=%h exp %h mix_out=%0d exp %0d active=%b exp %b",
                   $time, pulse_out, e.pulse, mix_out, e.mix, active, e.act);
      end
    end
  end

  // ---------------- tick generator ----------------
  initial begin
    enable_240hz = 1'b0;
    enable_120hz = 1'b0;
    forever begin
      @(negedge clk);
      enable_240hz = (rate240 > 0) && ($urandom_range(0, rate240 - 1) == 0);
      enable_120hz = (rate120 > 0) && ($urandom_range(0, rate120 - 1) == 0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic wr(input int ch, input int a, input int d);
    @(negedge clk);
    reg_wr = 1'b1; reg_ch = 3'(ch); reg_addr = 2'(a); reg_data = 8'(d);
    $display("[%0t] write ch=%0d reg=%0d data=0x%02h", $time, ch, a, d);
    @(negedge clk);
    reg_wr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_zero(input string name);
    n_cmp++;
    if (pulse_out !== '0 || mix_out !== '0 || active !== '0) begin
      n_bad++;
      $display("FAIL %s: pulse_out=%h mix_out=%0d active=%b, need all zero",
               name, pulse_out, mix_out, active);
    end
  endtask

  initial begin
    rst_n = 1'b0; reg_wr = 1'b0; reg_ch = '0; reg_addr = '0; reg_data = '0;
    rate240 = 2; rate120 = 2;
    repeat (10) begin
      @(negedge clk);
      reg_wr = 1'($urandom_range(0, 1)); reg_ch = 3'($urandom_range(0, 3));
      reg_addr = 2'($urandom_range(0, 3)); reg_data = 8'($urandom_range(0, 255));
    end
    @(negedge clk);
    reg_wr = 1'b0; rate240 = 0; rate120 = 0; rst_n = 1'b1;

    // Constant volume on channel 0
    wr(0, 0, 'hBF); wr(0, 2, 'h10); wr(0, 3, 'h08);
    idle(200);

    // Envelope decay on channel 1, then with loop
    wr(1, 0, 'h80); wr(1, 2, 'h20); wr(1, 3, 'h08);
    rate240 = 4; idle(120);
    wr(1, 0, 'hA0); wr(1, 3, 'h08);
    idle(150); rate240 = 0;

    // Length expiry on channel 2
    wr(2, 0, 'h9F); wr(2, 2, 'h10); wr(2, 3, 'h18);
    rate120 = 6; idle(60); rate120 = 0;

    // Sweep, negated on channels 0 and 1, then overflow on channel 0
    wr(0, 0, 'hBF); wr(0, 2, 'h00); wr(0, 3, 'h09); wr(0, 1, 'h89);
    wr(1, 0, 'hBF); wr(1, 2, 'h00); wr(1, 3, 'h09); wr(1, 1, 'h89);
    rate120 = 40; idle(200);
    wr(0, 2, 'h00); wr(0, 3, 'h0E); wr(0, 1, 'h81);
    idle(200); rate120 = 0;

    // Mixing: all channels at constant 15, duty 3; out-of-range channel writes
    for (int c = 0; c < NCH; c++) begin wr(c, 1, 'h00); wr(c, 0, 'hFF); wr(c, 2, 'h20); end
    for (int c = 0; c < NCH; c++) wr(c, 3, 'h08);
    wr(5, 0, 'h00); wr(5, 3, 'h08); wr(7, 2, 'h00);
    idle(300);

    // Randomized traffic with a mid-run asynchronous reset
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) begin rate240 = $urandom_range(0, 8); rate120 = $urandom_range(0, 8); end
      if (i == 700) begin
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_zero("async_reset");
        idle(3);
        rst_n = 1'b1;
      end
      if ($urandom_range(0, 3) == 0)
        wr($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 255));
      else
        idle(1);
    end
    rate240 = 0; rate120 = 0;
    idle(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time exceeded (compared %0d)", n_cmp);
    $fatal(1, "timeout");
  end
endmodule
